// File: rtl/serial_shift_out_if.sv
// serial_shift_out_if -- load handshake and serial output bundle for serial_shift_out.
//
// Signals:
//   load_valid  : producer requests a frame load
//   load_data   : frame to send (WIDTH bits, LSB goes out first)
//   load_ready  : shifter can accept a load this cycle
//   abort       : synchronous frame cancel
//   serial_out  : serial data line, idle level 0
//   bit_strobe  : one-cycle pulse at the last cycle of each bit period
//   busy        : frame in flight
//   done        : one-cycle pulse when a frame completes normally
//
// Modports: master = producer / line observer, slave = the shifter.
interface serial_shift_out_if #(
  parameter int WIDTH = 10
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             abort;
  logic             serial_out;
  logic             bit_strobe;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_data, abort,
    input  load_ready, serial_out, bit_strobe, busy, done
  );

  modport slave (
    input  load_valid, load_data, abort,
    output load_ready, serial_out, bit_strobe, busy, done
  );
endinterface

// File: rtl/serial_shift_out.sv
// serial_shift_out -- parallel-load, LSB-first serial shifter with a
// 2^PERIOD_BITS clock-cycle bit period.
//
// Ports:
//   clock   : single rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : serial_shift_out_if.slave (load handshake, abort, serial line,
//             bit_strobe, busy, done)
//
// Parameters:
//   WIDTH       : bits per frame (2..32)
//   PERIOD_BITS : bit period is 2^PERIOD_BITS cycles (1..24)
module serial_shift_out #(
  parameter int WIDTH       = 10,
  parameter int PERIOD_BITS = 22
) (
  input  logic               clock,
  input  logic               reset_n,
  serial_shift_out_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                 state_r;
  logic [WIDTH-1:0]       shift_r;
  logic [CNT_W-1:0]       bit_cnt_r;
  logic [PERIOD_BITS-1:0] period_r;
  logic                   serial_r;
  logic                   done_r;

  logic load_ready_s;
  logic accept_s;
  logic period_end_s;
  logic bit_strobe_s;

  // Handshake and strobe decode from the current registered state.
  assign load_ready_s = (state_r == IDLE) && !bus.abort;
  assign accept_s     = bus.load_valid && load_ready_s;
  assign period_end_s = (period_r == {PERIOD_BITS{1'b1}});
  assign bit_strobe_s = (state_r == SHIFT) && period_end_s;

  assign bus.load_ready = load_ready_s;
  assign bus.serial_out = serial_r;
  assign bus.bit_strobe = bit_strobe_s;
  assign bus.busy       = (state_r == SHIFT);
  assign bus.done       = done_r;

  // Frame FSM: load, per-period shifting, completion and abort.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      shift_r   <= {WIDTH{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
      period_r  <= {PERIOD_BITS{1'b0}};
      serial_r  <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (accept_s) begin
            state_r   <= SHIFT;
            shift_r   <= bus.load_data;
            bit_cnt_r <= {CNT_W{1'b0}};
            period_r  <= {PERIOD_BITS{1'b0}};
            // First bit is on the line the cycle after acceptance.
            serial_r  <= bus.load_data[0];
          end else begin
            period_r <= {PERIOD_BITS{1'b0}};
            serial_r <= 1'b0;
          end
        end
        SHIFT: begin
          done_r <= 1'b0;
          if (bus.abort) begin
            // Abort wins over everything, including the final strobe.
            state_r   <= IDLE;
            shift_r   <= {WIDTH{1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
            period_r  <= {PERIOD_BITS{1'b0}};
            serial_r  <= 1'b0;
          end else if (bit_strobe_s) begin
            period_r <= {PERIOD_BITS{1'b0}};
            if (bit_cnt_r == LAST_BIT) begin
              state_r   <= IDLE;
              shift_r   <= {WIDTH{1'b0}};
              bit_cnt_r <= {CNT_W{1'b0}};
              serial_r  <= 1'b0;
              done_r    <= 1'b1;
            end else begin
              shift_r   <= {1'b0, shift_r[WIDTH-1:1]};
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
              // Next bit goes straight to the registered line output.
              serial_r  <= shift_r[1];
            end
          end else begin
            period_r <= period_r + PERIOD_BITS'(1);
          end
        end
        default: begin
          state_r   <= IDLE;
          shift_r   <= {WIDTH{1'b0}};
          bit_cnt_r <= {CNT_W{1'b0}};
          period_r  <= {PERIOD_BITS{1'b0}};
          serial_r  <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_shift_out.sv
// tb_serial_shift_out -- self-checking bench for serial_shift_out with
// WIDTH=10, PERIOD_BITS=2 (4-cycle bit period). Expected line activity is
// computed from the cycle offset since acceptance: bit index = (t-1)/P,
// strobe when t is a multiple of P, done at t = W*P+1.
module tb_serial_shift_out;

  localparam int W  = 10;
  localparam int PB = 2;
  localparam int P  = 1 << PB;

  logic clock;
  logic reset_n;
  int   pass_cnt;
  int   total_cnt;

  serial_shift_out_if #(.WIDTH(W)) bus ();

  serial_shift_out #(.WIDTH(W), .PERIOD_BITS(PB)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Plays one frame from IDLE; optionally aborts at cycle abort_at and
  // optionally toggles load_valid/load_data while the frame is in flight.
  task automatic play_frame(input logic [W-1:0] data, input int abort_at,
                            input bit noise);
    logic [W-1:0] rx;
    int           strobes;
    logic         exp_ser;
    logic         exp_stb;
    rx      = '0;
    strobes = 0;
    bus.load_valid = 1'b1;
    bus.load_data  = data;
    bus.abort      = 1'b0;
    #1;
    total_cnt++;
    if (bus.load_ready !== 1'b1) $display("FAIL accept_ready got %b want 1", bus.load_ready);
    else pass_cnt++;
    next_cycle();
    for (int t = 1; t <= W * P; t++) begin
      exp_ser = data[(t - 1) / P];
      exp_stb = ((t % P) == 0);
      total_cnt++;
      if (bus.serial_out !== exp_ser || bus.busy !== 1'b1 || bus.bit_strobe !== exp_stb ||
          bus.done !== 1'b0)
        $display("FAIL frame_t%0d got ser=%b busy=%b stb=%b done=%b want ser=%b busy=1 stb=%b done=0",
                 t, bus.serial_out, bus.busy, bus.bit_strobe, bus.done, exp_ser, exp_stb);
      else pass_cnt++;
      if (bus.bit_strobe === 1'b1) begin
        rx = {bus.serial_out, rx[W-1:1]};
        strobes++;
      end
      if (noise) begin
        bus.load_valid = 1'($urandom_range(0, 1));
        bus.load_data  = W'($urandom);
      end else begin
        bus.load_valid = 1'b0;
      end
      if (t == abort_at) begin
        bus.abort = 1'b1;
        next_cycle();
        total_cnt++;
        if (bus.serial_out !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.bit_strobe !== 1'b0)
          $display("FAIL abort_t%0d got ser=%b busy=%b done=%b stb=%b want 0 0 0 0",
                   t, bus.serial_out, bus.busy, bus.done, bus.bit_strobe);
        else pass_cnt++;
        bus.abort      = 1'b0;
        bus.load_valid = 1'b0;
        next_cycle();
        total_cnt++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0)
          $display("FAIL abort_after got done=%b busy=%b want 0 0", bus.done, bus.busy);
        else pass_cnt++;
        return;
      end
      next_cycle();
    end
    bus.load_valid = 1'b0;
    total_cnt++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.serial_out !== 1'b0 ||
        bus.load_ready !== 1'b1)
      $display("FAIL done_cycle got done=%b busy=%b ser=%b rdy=%b want 1 0 0 1",
               bus.done, bus.busy, bus.serial_out, bus.load_ready);
    else pass_cnt++;
    total_cnt++;
    if (rx !== data || strobes != W)
      $display("FAIL loopback got rx=%b strobes=%0d want rx=%b strobes=%0d", rx, strobes, data, W);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.abort      = 1'b0;
    #2;
    total_cnt++;
    if (bus.serial_out !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.bit_strobe !== 1'b0 || bus.load_ready !== 1'b1)
      $display("FAIL reset_state got ser=%b busy=%b done=%b stb=%b rdy=%b want 0 0 0 0 1",
               bus.serial_out, bus.busy, bus.done, bus.bit_strobe, bus.load_ready);
    else pass_cnt++;
    #5;
    reset_n = 1'b1;
    next_cycle();
    total_cnt++;
    if (bus.busy !== 1'b0 || bus.serial_out !== 1'b0)
      $display("FAIL reset_idle got busy=%b ser=%b want 0 0", bus.busy, bus.serial_out);
    else pass_cnt++;
  endtask

  task automatic test_known_frame();
    play_frame(10'b1011001110, 0, 1'b0);
    next_cycle();
    total_cnt++;
    if (bus.done !== 1'b0) $display("FAIL done_width got %b want 0", bus.done);
    else pass_cnt++;
  endtask

  task automatic test_random_frames();
    for (int i = 0; i < 4; i++) begin
      play_frame(W'($urandom), 0, 1'b1);
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    d1 = W'($urandom);
    d2 = W'($urandom);
    play_frame(d1, 0, 1'b1);
    play_frame(d2, 0, 1'b0);
    next_cycle();
  endtask

  task automatic test_abort();
    play_frame(W'($urandom), 5 * P + 2, 1'b0);
    play_frame(W'($urandom), W * P, 1'b0);
    play_frame(10'b1011001110, 0, 1'b0);
    next_cycle();
  endtask

  task automatic test_abort_idle();
    bus.abort      = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = W'($urandom);
    #1;
    total_cnt++;
    if (bus.load_ready !== 1'b0) $display("FAIL abort_idle_ready got %b want 0", bus.load_ready);
    else pass_cnt++;
    next_cycle();
    total_cnt++;
    if (bus.busy !== 1'b0 || bus.serial_out !== 1'b0)
      $display("FAIL abort_idle_state got busy=%b ser=%b want 0 0", bus.busy, bus.serial_out);
    else pass_cnt++;
    bus.abort      = 1'b0;
    bus.load_valid = 1'b0;
    #1;
    total_cnt++;
    if (bus.load_ready !== 1'b1) $display("FAIL abort_idle_release got %b want 1", bus.load_ready);
    else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] d;
    d = W'($urandom) | W'(1);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    next_cycle();
    bus.load_valid = 1'b0;
    for (int t = 1; t < P; t++) next_cycle();
    // Now at t = P: bit_strobe high, first bit (1) on the line.
    total_cnt++;
    if (bus.bit_strobe !== 1'b1 || bus.serial_out !== 1'b1)
      $display("FAIL pre_reset got stb=%b ser=%b want 1 1", bus.bit_strobe, bus.serial_out);
    else pass_cnt++;
    #2;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if (bus.serial_out !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.bit_strobe !== 1'b0 || bus.load_ready !== 1'b1)
      $display("FAIL async_reset got ser=%b busy=%b done=%b stb=%b rdy=%b want 0 0 0 0 1",
               bus.serial_out, bus.busy, bus.done, bus.bit_strobe, bus.load_ready);
    else pass_cnt++;
    #2;
    reset_n        = 1'b1;
    d              = W'($urandom) | W'(1);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    next_cycle();
    bus.load_valid = 1'b0;
    total_cnt++;
    if (bus.busy !== 1'b1 || bus.serial_out !== 1'b1 || bus.done !== 1'b0)
      $display("FAIL post_reset_load got busy=%b ser=%b done=%b want 1 1 0",
               bus.busy, bus.serial_out, bus.done);
    else pass_cnt++;
    bus.abort = 1'b1;
    next_cycle();
    bus.abort = 1'b0;
    total_cnt++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL post_reset_abort got busy=%b done=%b want 0 0", bus.busy, bus.done);
    else pass_cnt++;
    next_cycle();
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_known_frame();
    test_random_frames();
    test_back_to_back();
    test_abort();
    test_abort_idle();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
